// File: rtl/gcd_pkg.sv
// Shared types and constants for the iterative GCD engine.
package gcd_pkg;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Build-time algorithm selectors for the ALGO parameter.
  localparam int ALGO_SUB = 0;  // subtract-swap
  localparam int ALGO_BIN = 1;  // binary (Stein)

endpackage : gcd_pkg

// File: rtl/gcd_if.sv
// Request/response bundle between a front-end (master) and the GCD engine (slave).
interface gcd_if #(
  parameter int W  = 8,
  parameter int CW = 16
) ();

  logic          start;
  logic [W-1:0]  a_in;
  logic [W-1:0]  b_in;
  logic          busy;
  logic          done;
  logic [W-1:0]  result;
  logic          zero_in;
  logic [CW-1:0] steps;

  modport master (
    output start, a_in, b_in,
    input  busy, done, result, zero_in, steps
  );

  modport slave (
    input  start, a_in, b_in,
    output busy, done, result, zero_in, steps
  );

endinterface : gcd_if

// File: rtl/gcd_step.sv
// One combinational GCD reduction step; the top applies it once per RUN cycle.
module gcd_step
  import gcd_pkg::*;
#(
  parameter int W    = 8,
  parameter int ALGO = ALGO_SUB,
  parameter int KW   = $clog2(W) + 1
) (
  input  logic [W-1:0]  a_i,
  input  logic [W-1:0]  b_i,
  input  logic [KW-1:0] k_i,
  output logic [W-1:0]  a_o,
  output logic [W-1:0]  b_o,
  output logic [KW-1:0] k_o,
  output logic          finish_o,
  output logic          zero_o
);

  // Finish detection first, then the algorithm-specific reduction.
  always_comb begin
    // NOTE: every output gets a default before any branch, so no path leaves
    // a value unassigned and no latch is inferred.
    a_o      = a_i;
    b_o      = b_i;
    k_o      = k_i;
    zero_o   = (a_i == '0) || (b_i == '0);
    finish_o = zero_o || (a_i == b_i);

    if (!finish_o) begin
      if (ALGO == ALGO_SUB) begin
        // a > b: subtract without wrap; otherwise swap so the larger is in a.
        if (a_i > b_i) begin
          a_o = a_i - b_i;
        end else begin
          a_o = b_i;
          b_o = a_i;
        end
      end else begin
        unique case ({a_i[0], b_i[0]})
          2'b00: begin
            // Common factor of two: strip it and remember it in k.
            a_o = a_i >> 1;
            b_o = b_i >> 1;
            k_o = k_i + KW'(1);
          end
          2'b01:   a_o = a_i >> 1;
          2'b10:   b_o = b_i >> 1;
          default: begin
            // Both odd and unequal: difference of the larger is even next step.
            if (a_i > b_i) begin
              a_o = a_i - b_i;
            end else begin
              a_o = b_i;
              b_o = a_i;
            end
          end
        endcase
      end
    end
  end

endmodule : gcd_step

// File: rtl/gcd_unit.sv
// Iterative GCD engine: start/busy/done handshake, one reduction step per cycle.
module gcd_unit
  import gcd_pkg::*;
#(
  parameter int W    = 8,
  parameter int ALGO = ALGO_SUB,
  parameter int CW   = 16
) (
  input  logic clk,
  input  logic rst,
  gcd_if.slave bus
);

  localparam int KW = $clog2(W) + 1;

  state_t        state_q;
  logic [W-1:0]  a_q, b_q;
  logic [KW-1:0] k_q;
  logic [CW-1:0] steps_q;
  logic [W-1:0]  result_q;
  logic          zero_q;
  logic          busy_q;
  logic          done_q;

  logic [W-1:0]  a_d, b_d;
  logic [KW-1:0] k_d;
  logic [CW-1:0] steps_d;
  logic [W-1:0]  result_d;
  logic          finish;
  logic          zero_op;

  gcd_step #(
    .W    (W),
    .ALGO (ALGO),
    .KW   (KW)
  ) u_step (
    .a_i      (a_q),
    .b_i      (b_q),
    .k_i      (k_q),
    .a_o      (a_d),
    .b_o      (b_d),
    .k_o      (k_d),
    .finish_o (finish),
    .zero_o   (zero_op)
  );

  // On finish one operand is zero or both are equal, so a|b is the odd part.
  assign result_d = W'((a_q | b_q) << k_q);
  assign steps_d  = (steps_q == '1) ? steps_q : steps_q + CW'(1);

  // Controller, operand datapath and output holding registers.
  always_ff @(posedge clk) begin
    // NOTE: the reset is synchronous and clears every register, including the
    // operand and result holders, so no stale value is visible after rst.
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      k_q      <= '0;
      steps_q  <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register samples
      // the pre-edge value of the others.
      done_q <= 1'b0;
      unique case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            a_q     <= bus.a_in;
            b_q     <= bus.b_in;
            k_q     <= '0;
            steps_q <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          if (finish) begin
            result_q <= result_d;
            zero_q   <= zero_op;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            k_q     <= k_d;
            steps_q <= steps_d;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.result  = result_q;
  assign bus.zero_in = zero_q;
  assign bus.steps   = steps_q;

endmodule : gcd_unit

// File: tb/tb_gcd_unit.sv
// Self-checking bench for gcd_unit across widths, algorithms and counter widths.
module tb_gcd_unit;
  import gcd_pkg::*;

  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus; start is routed to the instance picked by sel.
  int          sel;
  logic        start_s;
  logic [15:0] a_s, b_s;

  // 0: W8 sub, 1: W8 bin, 2: W16 sub, 3: W16 bin, 4: W8 sub with CW=4
  gcd_if #(.W(8),  .CW(16)) if0 ();
  gcd_if #(.W(8),  .CW(16)) if1 ();
  gcd_if #(.W(16), .CW(16)) if2 ();
  gcd_if #(.W(16), .CW(16)) if3 ();
  gcd_if #(.W(8),  .CW(4))  if4 ();

  gcd_unit #(.W(8),  .ALGO(ALGO_SUB), .CW(16)) u0 (.clk(clk), .rst(rst), .bus(if0));
  gcd_unit #(.W(8),  .ALGO(ALGO_BIN), .CW(16)) u1 (.clk(clk), .rst(rst), .bus(if1));
  gcd_unit #(.W(16), .ALGO(ALGO_SUB), .CW(16)) u2 (.clk(clk), .rst(rst), .bus(if2));
  gcd_unit #(.W(16), .ALGO(ALGO_BIN), .CW(16)) u3 (.clk(clk), .rst(rst), .bus(if3));
  gcd_unit #(.W(8),  .ALGO(ALGO_SUB), .CW(4))  u4 (.clk(clk), .rst(rst), .bus(if4));

  assign if0.start = start_s && (sel == 0);
  assign if1.start = start_s && (sel == 1);
  assign if2.start = start_s && (sel == 2);
  assign if3.start = start_s && (sel == 3);
  assign if4.start = start_s && (sel == 4);
  assign if0.a_in = a_s[7:0];  assign if0.b_in = b_s[7:0];
  assign if1.a_in = a_s[7:0];  assign if1.b_in = b_s[7:0];
  assign if2.a_in = a_s;       assign if2.b_in = b_s;
  assign if3.a_in = a_s;       assign if3.b_in = b_s;
  assign if4.a_in = a_s[7:0];  assign if4.b_in = b_s[7:0];

  // Observed outputs of the selected instance.
  logic        m_busy, m_done, m_zero;
  logic [15:0] m_result, m_steps;

  always_comb begin
    m_busy = 1'b0; m_done = 1'b0; m_zero = 1'b0; m_result = '0; m_steps = '0;
    case (sel)
      0: begin m_busy = if0.busy; m_done = if0.done; m_zero = if0.zero_in;
               m_result = 16'(if0.result); m_steps = 16'(if0.steps); end
      1: begin m_busy = if1.busy; m_done = if1.done; m_zero = if1.zero_in;
               m_result = 16'(if1.result); m_steps = 16'(if1.steps); end
      2: begin m_busy = if2.busy; m_done = if2.done; m_zero = if2.zero_in;
               m_result = if2.result; m_steps = if2.steps; end
      3: begin m_busy = if3.busy; m_done = if3.done; m_zero = if3.zero_in;
               m_result = if3.result; m_steps = if3.steps; end
      default: begin m_busy = if4.busy; m_done = if4.done; m_zero = if4.zero_in;
               m_result = 16'(if4.result); m_steps = 16'(if4.steps); end
    endcase
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Reference GCD by Euclid's remainder method.
  function automatic int ref_gcd(input int a, input int b);
    int t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Number of reduction steps the chosen algorithm takes on these operands.
  function automatic int ref_steps(input int a, input int b, input int algo);
    int n = 0;
    int t;
    while (a != 0 && b != 0 && a != b) begin
      n++;
      if (algo == 1 && a % 2 == 0 && b % 2 == 0) begin a = a / 2; b = b / 2; end
      else if (algo == 1 && a % 2 == 0) a = a / 2;
      else if (algo == 1 && b % 2 == 0) b = b / 2;
      else if (a > b) a = a - b;
      else begin t = a; a = b; b = t; end
    end
    return n;
  endfunction

  // Waits from observation cycle n (t0+n) until done is seen or the budget runs out.
  task automatic wait_done(input int n_start, input int budget, output int n, output int busy_cnt);
    n = n_start;
    busy_cnt = 0;
    while (!m_done && n <= budget) begin
      if (m_busy) busy_cnt++;
      @(negedge clk);
      n++;
    end
  endtask

  // One full transaction on instance s, checked against the given expectations.
  task automatic do_op(input string tag, input int s, input int a, input int b,
                       input int exp_res, input int exp_n, input int exp_steps, input int exp_zero);
    int n, bc;
    @(negedge clk);
    sel = s; a_s = 16'(a); b_s = 16'(b); start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    wait_done(1, exp_n + 8, n, bc);
    check({tag, " done_cycle"}, n, exp_n + 2);
    check({tag, " busy_cycles"}, bc, exp_n + 1);
    check({tag, " busy_in_done"}, m_busy, 0);
    check({tag, " result"}, m_result, exp_res);
    check({tag, " zero_in"}, m_zero, exp_zero);
    check({tag, " steps"}, m_steps, exp_steps);
    @(negedge clk);
    check({tag, " done_pulse_end"}, m_done, 0);
    check({tag, " result_held"}, m_result, exp_res);
  endtask

  // A start pulse mid-run must neither disturb nor queue behind the run.
  task automatic pulse_test(input string tag, input int s, input int algo);
    int n, bc, en;
    en = ref_steps(48, 18, algo);
    @(negedge clk);
    sel = s; a_s = 16'd48; b_s = 16'd18; start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    @(negedge clk);
    a_s = 16'd5; b_s = 16'd7; start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    wait_done(3, en + 8, n, bc);
    check({tag, " done_cycle"}, n, en + 2);
    check({tag, " result"}, m_result, 6);
    @(negedge clk);
    check({tag, " not_restarted"}, m_busy, 0);
  endtask

  // Start held high: the second request is accepted in the DONE cycle.
  task automatic b2b_test(input string tag, input int s, input int algo);
    int n, bc, n1, n2;
    n1 = ref_steps(48, 18, algo);
    n2 = ref_steps(35, 64, algo);
    @(negedge clk);
    sel = s; a_s = 16'd48; b_s = 16'd18; start_s = 1'b1;
    @(negedge clk);
    a_s = 16'd35; b_s = 16'd64;
    wait_done(1, n1 + 8, n, bc);
    check({tag, " first_done_cycle"}, n, n1 + 2);
    check({tag, " first_result"}, m_result, 6);
    @(negedge clk);
    start_s = 1'b0;
    check({tag, " second_captured"}, m_busy, 1);
    @(negedge clk);
    wait_done(2, n2 + 8, n, bc);
    check({tag, " second_done_cycle"}, n, n2 + 2);
    check({tag, " second_result"}, m_result, 1);
    check({tag, " second_steps"}, m_steps, n2);
  endtask

  typedef struct {
    int sel;
    int a;
    int b;
    int res;
    int raw_n;
    int steps;
    int zero;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int n, bc, seen_done, a, b, g, algo, mask;

    sel = 0; start_s = 1'b0; a_s = '0; b_s = '0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    for (int s = 0; s < 5; s++) begin
      sel = s;
      #1;
      check($sformatf("reset[%0d] outputs", s),
            {m_busy, m_done, m_zero, m_result, m_steps[12:0]}, 0);
    end
    rst = 1'b0;

    vecs[0] = '{0, 12,  8,  4,   3,  3, 0};
    vecs[1] = '{1, 12,  8,  4,   5,  5, 0};
    vecs[2] = '{1,  0,  0,  0,   0,  0, 1};
    vecs[3] = '{2, 48, 18,  6,   6,  6, 0};
    vecs[4] = '{3, 48, 18,  6,   7,  7, 0};
    vecs[5] = '{2, 35, 64,  1,  16, 16, 0};
    vecs[6] = '{3, 35, 64,  1,  13, 13, 0};
    vecs[7] = '{4, 255, 1,  1, 254, 15, 0};
    vecs[8] = '{0,  0,  9,  9,   0,  0, 1};
    for (int i = 0; i < 9; i++)
      do_op($sformatf("vec%0d", i), vecs[i].sel, vecs[i].a, vecs[i].b,
            vecs[i].res, vecs[i].raw_n, vecs[i].steps, vecs[i].zero);

    b2b_test("b2b_sub", 2, 0);
    b2b_test("b2b_bin", 3, 1);
    pulse_test("pulse_sub", 2, 0);
    pulse_test("pulse_bin", 3, 1);

    // Reset in the middle of a long run on the W8 subtract instance.
    @(negedge clk);
    sel = 0; a_s = 16'd255; b_s = 16'd1; start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_mid busy_before", m_busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid outputs", {m_busy, m_done, m_zero, m_result, m_steps}, 0);
    seen_done = 0;
    repeat (20) begin
      @(negedge clk);
      if (m_done) seen_done = 1;
    end
    check("rst_mid no_done", seen_done, 0);

    // Randomised operands against the reference model.
    for (int s = 0; s < 4; s++) begin
      algo = s % 2;
      mask = (s < 2) ? 255 : 65535;
      for (int i = 0; i < 10; i++) begin
        if (s < 2) begin
          a = $urandom_range(0, 255);
          b = $urandom_range(0, 255);
        end else begin
          g = $urandom_range(1, 60);
          a = g * $urandom_range(0, 60);
          b = g * $urandom_range(0, 60);
        end
        if ($urandom_range(0, 9) == 0) a = 0;
        n = ref_steps(a, b, algo);
        do_op($sformatf("rnd s%0d (%0d,%0d)", s, a, b), s, a & mask, b & mask,
              ref_gcd(a, b), n, n, (a == 0 || b == 0) ? 1 : 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_gcd_unit
